rv_memory: RTL and testbench



---
 rtl/rv_memory.sv | 197 +++++++++++++++++++
 tb/tb_rv_memory.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_memory.sv
// rv_memory: memory-access stage of the RV32I pipeline.
// Issues data-bus loads/stores over a req/ack handshake, lane-aligns store
// data and byte enables, stalls upstream while an access is outstanding and
// registers the raw read word plus pass-through controls for rv_write.
// Optional feature macro: RV_MISALIGN_TRAP_EN (misaligned accesses are
// suppressed and flagged on o_misaligned instead of being issued).
//
// Handshake: o_bus_req is held high with stable request fields until a cycle
// in which i_bus_ack is also high; that cycle completes the access and
// i_bus_rdata is sampled in it. Ack without a request is ignored.
module rv_memory (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_res_src,
    input  logic [29:0] i_pc_p4,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_data,
    output logic [31:0] o_alu_result,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [1:0]  o_res_src,
    output logic [29:0] o_pc_p4,
    output logic [2:0]  o_funct3,
    output logic        o_misaligned,
    output logic        o_dbg_state
);

    // Must match RESULT_SRC_MEMORY in rv_defines.vh.
    localparam logic [1:0] RESULT_SRC_MEMORY = 2'b01;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  size;
    logic        is_access;
    logic        misaligned;
    logic        misalign_trap;
    logic        mem_op;
    logic        bus_req;
    logic        load_done;

    logic [31:0] data_q, data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  res_src_q, res_src_d;
    logic [29:0] pc_p4_q, pc_p4_d;
    logic [2:0]  funct3_q, funct3_d;

    // Classify the instruction and build lane-aligned byte enables / data.
    always_comb begin
        size        = i_funct3[1:0];
        is_access   = i_valid & (i_mem_write | (i_res_src == RESULT_SRC_MEMORY))
                      & (size != 2'b11);
`ifdef RV_MISALIGN_TRAP_EN
        misaligned  = ((size == 2'b01) & i_alu_result[0]) |
                      ((size == 2'b10) & (i_alu_result[1:0] != 2'b00));
`else
        misaligned  = 1'b0;
`endif
        misalign_trap = is_access & misaligned;
        mem_op        = is_access & ~misaligned;
        o_bus_addr    = i_alu_result[31:2];
        o_bus_we      = i_mem_write;
        o_bus_sel     = 4'b0000;
        o_bus_wdata   = i_wdata;
        case (size)
            2'b00: begin
                o_bus_sel   = 4'b0001 << i_alu_result[1:0];
                o_bus_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_bus_sel   = i_alu_result[1] ? 4'b1100 : 4'b0011;
                o_bus_wdata = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                o_bus_sel   = 4'b1111;
                o_bus_wdata = i_wdata;
            end
            default: begin
                o_bus_sel   = 4'b0000;
                o_bus_wdata = i_wdata;
            end
        endcase
    end

    // Access FSM: IDLE issues a request for a memory op, WAIT holds it until ack.
    always_comb begin
        state_d = state_q;
        bus_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus_req = mem_op;
                if (mem_op & ~i_bus_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                bus_req = 1'b1;
                if (i_bus_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset drops the request immediately, abandoning any outstanding access.
        o_bus_req   = bus_req & i_reset_n;
        o_stall     = o_bus_req & ~i_bus_ack;
        load_done   = o_bus_req & i_bus_ack & ~i_mem_write;
        o_dbg_state = state_q;
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Output register next-state: load when free, insert a bubble when stalled.
    always_comb begin
        data_d       = data_q;
        alu_result_d = alu_result_q;
        reg_write_d  = 1'b0;
        rd_d         = rd_q;
        res_src_d    = res_src_q;
        pc_p4_d      = pc_p4_q;
        funct3_d     = funct3_q;
        if (!o_stall) begin
            data_d       = load_done ? i_bus_rdata : 32'h0;
            alu_result_d = i_alu_result;
            reg_write_d  = i_valid & i_reg_write & ~misalign_trap;
            rd_d         = i_rd;
            res_src_d    = i_res_src;
            pc_p4_d      = i_pc_p4;
            funct3_d     = i_funct3;
        end
    end

    // Output register toward rv_write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_q       <= 32'h0;
            alu_result_q <= 32'h0;
            reg_write_q  <= 1'b0;
            rd_q         <= 5'h0;
            res_src_q    <= 2'h0;
            pc_p4_q      <= 30'h0;
            funct3_q     <= 3'h0;
        end else begin
            data_q       <= data_d;
            alu_result_q <= alu_result_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            res_src_q    <= res_src_d;
            pc_p4_q      <= pc_p4_d;
            funct3_q     <= funct3_d;
        end
    end

`ifdef RV_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    // Misalignment flag: set for the trapped instruction, cleared by bubbles.
    always_comb begin
        misaligned_d = o_stall ? 1'b0 : misalign_trap;
    end

    // Misalignment flag register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) misaligned_q <= 1'b0;
        else            misaligned_q <= misaligned_d;
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_data       = data_q;
    assign o_alu_result = alu_result_q;
    assign o_reg_write  = reg_write_q;
    assign o_rd         = rd_q;
    assign o_res_src    = res_src_q;
    assign o_pc_p4      = pc_p4_q;
    assign o_funct3     = funct3_q;

endmodule

// File: tb/tb_rv_memory.sv
// tb_rv_memory: self-checking bench for rv_memory.
// Expected output-register contents are pushed to exp_q when a transaction is
// driven and popped/compared after the completing clock edge.
module tb_rv_memory;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;

    logic        i_clk, i_reset_n, i_valid, i_mem_write, i_reg_write, i_bus_ack;
    logic [31:0] i_alu_result, i_wdata, i_bus_rdata;
    logic [4:0]  i_rd;
    logic [1:0]  i_res_src;
    logic [29:0] i_pc_p4;
    logic [2:0]  i_funct3;
    logic        o_stall, o_bus_req, o_bus_we, o_reg_write, o_misaligned, o_dbg_state;
    logic [29:0] o_bus_addr, o_pc_p4;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata, o_data, o_alu_result;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;
    logic [2:0]  o_funct3;

    logic [105:0] exp_q[$];
    logic [105:0] obs;
    logic [105:0] e;
    int checks = 0;
    int errors = 0;

    rv_memory dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_alu_result(i_alu_result), .i_wdata(i_wdata), .i_mem_write(i_mem_write),
        .i_reg_write(i_reg_write), .i_rd(i_rd), .i_res_src(i_res_src),
        .i_pc_p4(i_pc_p4), .i_funct3(i_funct3), .o_stall(o_stall),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack),
        .i_bus_rdata(i_bus_rdata), .o_data(o_data), .o_alu_result(o_alu_result),
        .o_reg_write(o_reg_write), .o_rd(o_rd), .o_res_src(o_res_src),
        .o_pc_p4(o_pc_p4), .o_funct3(o_funct3), .o_misaligned(o_misaligned),
        .o_dbg_state(o_dbg_state)
    );

    assign obs = {o_data, o_alu_result, o_reg_write, o_rd, o_res_src, o_pc_p4, o_funct3, o_misaligned};

    // Clock / reset block
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Upstream contract: valid is held while the stage is stalled.
    always @(posedge i_clk) begin
        if (i_reset_n && o_stall) assert (i_valid) else $error("i_valid dropped during stall");
    end

    function automatic logic [105:0] pack(input logic [31:0] d, input logic [31:0] alu,
                                          input logic rw, input logic [4:0] rd,
                                          input logic [1:0] rs, input logic [29:0] pc,
                                          input logic [2:0] f3, input logic mis);
        return {d, alu, rw, rd, rs, pc, f3, mis};
    endfunction

    // Driver tasks
    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic we, input logic rw, input logic [4:0] rd,
                         input logic [1:0] rs, input logic [29:0] pc, input logic [2:0] f3,
                         input logic ack, input logic [31:0] rdata);
        i_valid = v; i_alu_result = alu; i_wdata = wd; i_mem_write = we;
        i_reg_write = rw; i_rd = rd; i_res_src = rs; i_pc_p4 = pc; i_funct3 = f3;
        i_bus_ack = ack; i_bus_rdata = rdata;
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        drive(1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 5'd1, RS_MEM, 30'h10, 3'b010, 1'b0, 32'h0);
        tick();
        tick();
        #1;
        checks++;
        if (obs !== 106'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        checks++;
        if ({o_bus_req, o_stall, o_misaligned} !== 3'b000) begin
            errors++; $display("FAIL reset_req: req/stall/mis=%b want 000", {o_bus_req, o_stall, o_misaligned});
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, RS_ALU, 30'h0, 3'b000, 1'b0, 32'h0);
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_sw_zero_wait();
        drive(1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 5'd2, RS_ALU, 30'h21, 3'b010, 1'b1, 32'h0);
        #1;
        checks++;
        if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata, o_stall} !==
            {1'b1, 1'b1, 30'h40, 4'b1111, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL sw_request: req=%b we=%b addr=%h sel=%b wd=%h stall=%b want 1 1 40 1111 deadbeef 0",
                               o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata, o_stall);
        end
        exp_q.push_back(pack(32'h0, 32'h100, 1'b0, 5'd2, RS_ALU, 30'h21, 3'b010, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL sw_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_sb_wait();
        drive(1'b1, 32'h103, 32'h000000A5, 1'b1, 1'b0, 5'd3, RS_ALU, 30'h22, 3'b000, 1'b0, 32'h0);
        for (int w = 0; w < 3; w++) begin
            i_bus_rdata = $urandom;
            #1;
            checks++;
            if ({o_bus_req, o_stall, o_bus_sel, o_bus_wdata} !== {1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5}) begin
                errors++; $display("FAIL sb_wait_req[%0d]: req=%b stall=%b sel=%b wd=%h want 1 1 1000 a5a5a5a5",
                                   w, o_bus_req, o_stall, o_bus_sel, o_bus_wdata);
            end
            tick();
            checks++;
            if ({o_reg_write, o_alu_result} !== {1'b0, 32'h100}) begin
                errors++; $display("FAIL sb_bubble[%0d]: rw=%b alu=%h want 0 00000100", w, o_reg_write, o_alu_result);
            end
        end
        i_bus_ack = 1'b1;
        #1;
        checks++;
        if ({o_bus_req, o_stall} !== 2'b10) begin
            errors++; $display("FAIL sb_ack: req=%b stall=%b want 1 0", o_bus_req, o_stall);
        end
        exp_q.push_back(pack(32'h0, 32'h103, 1'b0, 5'd3, RS_ALU, 30'h22, 3'b000, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL sb_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_lh_wait();
        drive(1'b1, 32'h202, 32'h0, 1'b0, 1'b1, 5'd7, RS_MEM, 30'h23, 3'b001, 1'b0, 32'h0);
        #1;
        checks++;
        if ({o_bus_req, o_bus_we, o_stall, o_bus_sel, o_bus_addr} !== {1'b1, 1'b0, 1'b1, 4'b1100, 30'h80}) begin
            errors++; $display("FAIL lh_req: req=%b we=%b stall=%b sel=%b addr=%h want 1 0 1 1100 80",
                               o_bus_req, o_bus_we, o_stall, o_bus_sel, o_bus_addr);
        end
        tick();
        checks++;
        if ({o_reg_write, o_rd} !== {1'b0, 5'd3}) begin
            errors++; $display("FAIL lh_hold: rw=%b rd=%0d want 0 3", o_reg_write, o_rd);
        end
        i_bus_ack = 1'b1; i_bus_rdata = 32'h80011234;
        exp_q.push_back(pack(32'h80011234, 32'h202, 1'b1, 5'd7, RS_MEM, 30'h23, 3'b001, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL lh_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        // ALU op with a stray ack: no request, ack ignored, o_data stays 0.
        drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5, RS_ALU, 30'h30, 3'b000, 1'b1, 32'hFFFFFFFF);
        #1;
        checks++;
        if ({o_bus_req, o_stall} !== 2'b00) begin
            errors++; $display("FAIL alu_noreq: req=%b stall=%b want 0 0", o_bus_req, o_stall);
        end
        exp_q.push_back(pack(32'h0, 32'h1234, 1'b1, 5'd5, RS_ALU, 30'h30, 3'b000, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL alu_output: got %h want %h", obs, e);
        end
        drive(1'b1, 32'h300, 32'h0, 1'b0, 1'b1, 5'd6, RS_MEM, 30'h31, 3'b010, 1'b1, 32'hCAFEF00D);
        #1;
        checks++;
        if ({o_bus_req, o_bus_we, o_stall, o_bus_sel, o_bus_addr} !== {1'b1, 1'b0, 1'b0, 4'b1111, 30'hC0}) begin
            errors++; $display("FAIL lw_b2b_req: req=%b we=%b stall=%b sel=%b addr=%h want 1 0 0 1111 c0",
                               o_bus_req, o_bus_we, o_stall, o_bus_sel, o_bus_addr);
        end
        exp_q.push_back(pack(32'hCAFEF00D, 32'h300, 1'b1, 5'd6, RS_MEM, 30'h31, 3'b010, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL lw_b2b_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_invalid_size();
        drive(1'b1, 32'h55, 32'h12345678, 1'b1, 1'b1, 5'd4, RS_ALU, 30'h40, 3'b011, 1'b0, 32'h0);
        #1;
        checks++;
        if ({o_bus_req, o_stall, o_bus_sel} !== {1'b0, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL size11_noreq: req=%b stall=%b sel=%b want 0 0 0000", o_bus_req, o_stall, o_bus_sel);
        end
        exp_q.push_back(pack(32'h0, 32'h55, 1'b1, 5'd4, RS_ALU, 30'h40, 3'b011, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL size11_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 32'h400, 32'h0, 1'b0, 1'b1, 5'd8, RS_MEM, 30'h50, 3'b010, 1'b0, 32'h0);
        tick();
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++; $display("FAIL rst_wait_pre: stall=%b want 1", o_stall);
        end
        #1 i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_bus_req, o_stall, obs} !== {2'b00, 106'h0}) begin
            errors++; $display("FAIL rst_wait_clear: req=%b stall=%b out=%h want 0 0 0", o_bus_req, o_stall, obs);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        drive(1'b1, 32'h104, 32'h0, 1'b0, 1'b1, 5'd9, RS_MEM, 30'h51, 3'b010, 1'b1, 32'h11223344);
        #1;
        checks++;
        if ({o_bus_req, o_stall, o_bus_addr} !== {1'b1, 1'b0, 30'h41}) begin
            errors++; $display("FAIL rst_restart_req: req=%b stall=%b addr=%h want 1 0 41", o_bus_req, o_stall, o_bus_addr);
        end
        exp_q.push_back(pack(32'h11223344, 32'h104, 1'b1, 5'd9, RS_MEM, 30'h51, 3'b010, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL rst_restart_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 32'h102, 32'h0, 1'b0, 1'b1, 5'd9, RS_MEM, 30'h60, 3'b010, 1'b0, 32'h55AA55AA);
`ifdef RV_MISALIGN_TRAP_EN
        #1;
        checks++;
        if ({o_bus_req, o_stall} !== 2'b00) begin
            errors++; $display("FAIL misalign_noreq: req=%b stall=%b want 0 0", o_bus_req, o_stall);
        end
        exp_q.push_back(pack(32'h0, 32'h102, 1'b0, 5'd9, RS_MEM, 30'h60, 3'b010, 1'b1));
`else
        i_bus_ack = 1'b1;
        #1;
        checks++;
        if ({o_bus_req, o_stall, o_bus_sel, o_bus_addr} !== {1'b1, 1'b0, 4'b1111, 30'h40}) begin
            errors++; $display("FAIL misalign_req: req=%b stall=%b sel=%b addr=%h want 1 0 1111 40",
                               o_bus_req, o_stall, o_bus_sel, o_bus_addr);
        end
        exp_q.push_back(pack(32'h55AA55AA, 32'h102, 1'b1, 5'd9, RS_MEM, 30'h60, 3'b010, 1'b0));
`endif
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL misalign_output: got %h want %h", obs, e);
        end
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic        st;
        logic [31:0] a, wd, rdata;
        logic [3:0]  esel;
        logic [31:0] ewd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          nw;
        for (int k = 0; k < 24; k++) begin
            sz = 2'($urandom_range(0, 2));
            st = 1'($urandom_range(0, 1));
            a  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            wd = $urandom; rdata = $urandom;
            rd = 5'($urandom_range(1, 31));
            f3 = {st ? 1'b0 : 1'($urandom_range(0, 1)), sz};
            nw = $urandom_range(0, 2);
            case (sz)
                2'd0:    begin esel = 4'b0001 << a[1:0];          ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
                2'd1:    begin esel = a[1] ? 4'b1100 : 4'b0011;   ewd = {wd[15:0], wd[15:0]}; end
                default: begin esel = 4'b1111;                    ewd = wd; end
            endcase
            drive(1'b1, a, wd, st, ~st, rd, st ? RS_ALU : RS_MEM, 30'(k), f3, 1'b0, 32'h0);
            for (int w = 0; w < nw; w++) begin
                i_bus_rdata = $urandom;
                #1;
                checks++;
                if ({o_bus_req, o_stall, o_bus_we, o_bus_sel, o_bus_wdata, o_bus_addr} !==
                    {1'b1, 1'b1, st, esel, ewd, a[31:2]}) begin
                    errors++; $display("FAIL rand_wait[%0d]: req=%b stall=%b we=%b sel=%b wd=%h addr=%h want 1 1 %b %b %h %h",
                                       k, o_bus_req, o_stall, o_bus_we, o_bus_sel, o_bus_wdata, o_bus_addr,
                                       st, esel, ewd, a[31:2]);
                end
                tick();
                checks++;
                if (o_reg_write !== 1'b0) begin
                    errors++; $display("FAIL rand_bubble[%0d]: rw=%b want 0", k, o_reg_write);
                end
            end
            i_bus_ack = 1'b1; i_bus_rdata = rdata;
            #1;
            checks++;
            if ({o_bus_req, o_stall, o_bus_we, o_bus_sel, o_bus_wdata, o_bus_addr} !==
                {1'b1, 1'b0, st, esel, ewd, a[31:2]}) begin
                errors++; $display("FAIL rand_ack[%0d]: req=%b stall=%b we=%b sel=%b wd=%h addr=%h want 1 0 %b %b %h %h",
                                   k, o_bus_req, o_stall, o_bus_we, o_bus_sel, o_bus_wdata, o_bus_addr,
                                   st, esel, ewd, a[31:2]);
            end
            exp_q.push_back(pack(st ? 32'h0 : rdata, a, ~st, rd, st ? RS_ALU : RS_MEM, 30'(k), f3, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL rand_output[%0d]: got %h want %h", k, obs, e);
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, RS_ALU, 30'h0, 3'b000, 1'b0, 32'h0);
        @(negedge i_clk);
        test_reset();
        test_sw_zero_wait();
        test_sb_wait();
        test_lh_wait();
        test_back_to_back();
        test_invalid_size();
        test_reset_in_wait();
        test_misalign();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
